// File: rtl/vc_latency_ctrl_pkg.sv
// Shared width helpers and event bundle for the latency/credit controller and its output queue.
package vc_latency_ctrl_pkg;

  // Width able to hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Queue pointer width; never below one bit so a depth-1 queue still has a pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic issue;
    logic capture;
    logic dequeue;
  } ctrl_evt_t;

endpackage

// File: rtl/vc_ctrl_fifo.sv
// Circular output queue: enq/deq strobes, combinational head, count; capture and dequeue may coincide at any fill level.
module vc_ctrl_fifo
  import vc_latency_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enq,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic                  valid,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  do_enq, do_deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A full queue still accepts a write on the edge that frees its head slot.
  assign do_deq = deq & (cnt_q != '0);
  assign do_enq = enq & ((cnt_q != DEPTH_C) | do_deq);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_enq) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_enq, do_deq})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr_q] <= enq_data;
  end

  assign deq_data = mem[rd_ptr_q];
  assign valid    = (cnt_q != '0);
  assign count    = cnt_q;

endmodule

// File: rtl/vc_latency_credit_ctrl.sv
// Issue/credit controller for a fixed-latency register-chain datapath feeding an in-order output queue.
module vc_latency_credit_ctrl
  import vc_latency_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CYCLES = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_val,
  output logic                  in_rdy,
  output logic                  dp_issue,
  input  logic [DATA_WIDTH-1:0] dp_result,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_msg,
  output logic [CNT_W-1:0]      occupancy
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_CYCLES-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  full_q, full_d;
  logic [CNT_W-1:0]      fifo_cnt;
  ctrl_evt_t             evt;

  // Ready comes only from a flop; reset_n gating holds it low in reset and
  // lets it rise the moment reset releases (occupancy is then zero).
  assign in_rdy   = reset_n & ~full_q;
  assign dp_issue = in_val & in_rdy;

  assign evt.issue   = dp_issue;
  assign evt.capture = vld_q[NUM_CYCLES-1];
  assign evt.dequeue = out_val & out_rdy;

  always_comb begin
    vld_d[0] = evt.issue;
    for (int i = 1; i < NUM_CYCLES; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Occupancy counts a word from issue until dequeue, so credits also cover
  // results still in the datapath and a capture always finds room.
  always_comb begin
    case ({evt.issue, evt.dequeue})
      2'b10:   occ_d = occ_q + CNT_ONE;
      2'b01:   occ_d = occ_q - CNT_ONE;
      default: occ_d = occ_q;
    endcase
    full_d = (occ_d >= DEPTH_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      occ_q  <= occ_d;
      full_q <= full_d;
    end
  end

  vc_ctrl_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq      (evt.capture),
    .enq_data (dp_result),
    .deq      (out_rdy),
    .deq_data (out_msg),
    .valid    (out_val),
    .count    (fifo_cnt)
  );

  assign occupancy = occ_q;

  logic unused_ok;
  assign unused_ok = ^fifo_cnt;

endmodule
